// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one iterative divider between NUM_REQ requesters,
// keeping a single operation outstanding and returning results over a valid/ready port.
module divider_arbiter #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int NUM_REQ    = 4,
    localparam int total_width = exp_width + mant_width,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*total_width-1:0] req_a_i,
    input  logic [NUM_REQ*total_width-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0]           req_round_mode_i,
    input  logic [NUM_REQ-1:0]             req_cancel_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    input  logic [NUM_REQ-1:0]             resp_ready_i,
    output logic [total_width-1:0]         resp_data_o,
    output logic [4:0]                     resp_exc_o,
    output logic                           busy_o,
    output logic                           div_in_valid_o,
    output logic [total_width-1:0]         div_a_o,
    output logic [total_width-1:0]         div_b_o,
    output logic [2:0]                     div_round_mode_o,
    output logic                           div_cancel_o,
    input  logic                           div_in_ready_i,
    input  logic                           div_out_valid_i,
    input  logic [total_width-1:0]         div_out_i,
    input  logic [4:0]                     div_exceptions_i
);

    // state | meaning
    // IDLE  | waiting for any req_valid, grant round-robin from rr_ptr
    // ISSUE | presenting latched operands to the divider
    // WAIT  | operation in flight, waiting for div_out_valid
    // RESP  | result held for the owner until resp_ready
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [total_width-1:0] a_q, a_d;
    logic [total_width-1:0] b_q, b_d;
    logic [2:0]             rm_q, rm_d;
    logic [total_width-1:0] res_q, res_d;
    logic [4:0]             exc_q, exc_d;

    logic [total_width-1:0] a_arr  [NUM_REQ];
    logic [total_width-1:0] b_arr  [NUM_REQ];
    logic [2:0]             rm_arr [NUM_REQ];

    logic                   found;
    logic [ID_W-1:0]        winner;
    logic [ID_W-1:0]        ptr_after_owner;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a_i[g*total_width +: total_width];
        assign b_arr[g]  = req_b_i[g*total_width +: total_width];
        assign rm_arr[g] = req_round_mode_i[g*3 +: 3];
    end

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // First set req_valid bit at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_i[wrap_add(rr_ptr_q, k)]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr_q, k);
            end
        end
    end

    assign ptr_after_owner = wrap_add(owner_q, 1);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        a_d            = a_q;
        b_d            = b_q;
        rm_d           = rm_q;
        res_d          = res_q;
        exc_d          = exc_q;
        req_ready_o    = '0;
        resp_valid_o   = '0;
        div_in_valid_o = 1'b0;
        div_cancel_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_o[winner] = 1'b1;
                    owner_d             = winner;
                    a_d                 = a_arr[winner];
                    b_d                 = b_arr[winner];
                    rm_d                = rm_arr[winner];
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                // A cancel here withdraws the operation before the divider ever sees it.
                if (req_cancel_i[owner_q]) begin
                    rr_ptr_d = ptr_after_owner;
                    state_d  = IDLE;
                end else begin
                    div_in_valid_o = 1'b1;
                    if (div_in_ready_i) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (req_cancel_i[owner_q]) begin
                    div_cancel_o = 1'b1;
                    rr_ptr_d     = ptr_after_owner;
                    state_d      = IDLE;
                end else if (div_out_valid_i) begin
                    res_d   = div_out_i;
                    exc_d   = div_exceptions_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_o[owner_q] = 1'b1;
                if (resp_ready_i[owner_q]) begin
                    rr_ptr_d = ptr_after_owner;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rm_q     <= '0;
            res_q    <= '0;
            exc_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rm_q     <= rm_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign div_a_o          = a_q;
    assign div_b_o          = b_q;
    assign div_round_mode_o = rm_q;
    assign resp_data_o      = res_q;
    assign resp_exc_o       = exc_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: a behavioural divider stub plus requester agents, with
// grant order and results predicted from round-robin rules and the stub's quotient function.
module tb_divider_arbiter;

    localparam int N  = 4;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*TW-1:0] req_a = '0;
    logic [N*TW-1:0] req_b = '0;
    logic [N*3-1:0]  req_rm = '0;
    logic [N-1:0]  req_cancel = '0;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready = '0;
    logic [TW-1:0] resp_data;
    logic [4:0]    resp_exc;
    logic          busy;
    logic          div_in_valid;
    logic [TW-1:0] div_a;
    logic [TW-1:0] div_b;
    logic [2:0]    div_rm;
    logic          div_cancel;
    logic          div_in_ready;
    logic          div_out_valid = 1'b0;
    logic [TW-1:0] div_out = '0;
    logic [4:0]    div_exceptions = '0;

    always #5 clk = ~clk;

    divider_arbiter #(.exp_width(8), .mant_width(24), .NUM_REQ(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_round_mode_i(req_rm),
        .req_cancel_i(req_cancel),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_exc_o(resp_exc), .busy_o(busy),
        .div_in_valid_o(div_in_valid), .div_a_o(div_a), .div_b_o(div_b),
        .div_round_mode_o(div_rm), .div_cancel_o(div_cancel),
        .div_in_ready_i(div_in_ready), .div_out_valid_i(div_out_valid),
        .div_out_i(div_out), .div_exceptions_i(div_exceptions)
    );

    int errors = 0;
    int checks = 0;

    // Stub divider: known test vectors give true quotients, others a fixed scramble.
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'hC140_0000 && b == 32'h4080_0000) return 32'hC040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {29'd0, rm};
    endfunction

    function automatic logic [4:0] exc_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 5'd0;
        if (a == 32'hC140_0000 && b == 32'h4080_0000) return 5'd0;
        return a[4:0] ^ b[9:5] ^ {2'b00, rm};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    logic       stub_busy = 1'b0;
    int         stub_cnt = 0;
    logic [31:0] stub_res = '0;
    logic [4:0] stub_exc = '0;
    int         stub_lat = 2;
    bit         stub_lat_rand = 1'b0;
    bit         in_ready_en = 1'b1;
    int         inval_cycles = 0;
    int         cancel_cycles = 0;
    int         issue_cnt = 0;
    int         outv_cnt = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    assign div_in_ready = in_ready_en && !stub_busy;

    always @(posedge clk) begin
        div_out_valid <= 1'b0;
        if (div_in_valid) inval_cycles <= inval_cycles + 1;
        if (div_cancel) cancel_cycles <= cancel_cycles + 1;
        if (div_cancel) begin
            stub_busy <= 1'b0;
        end else if (stub_busy) begin
            if (stub_cnt == 0) begin
                div_out_valid  <= 1'b1;
                div_out        <= stub_res;
                div_exceptions <= stub_exc;
                stub_busy      <= 1'b0;
                outv_cnt       <= outv_cnt + 1;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (div_in_valid && div_in_ready) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat_rand ? int'($urandom_range(0, 5)) : stub_lat;
            stub_res  <= div_model(div_a, div_b, div_rm);
            stub_exc  <= exc_model(div_a, div_b, div_rm);
            last_a    <= div_a;
            last_b    <= div_b;
            issue_cnt <= issue_cnt + 1;
        end
    end

    logic [N-1:0] pend = '0;
    logic [31:0]  op_a [N];
    logic [31:0]  op_b [N];
    logic [2:0]   op_rm [N];
    bit           cont [N];
    bit           rand_rr = 1'b0;
    int           mptr = 0;

    int           g_id [$];
    logic [31:0]  g_exp [$];
    logic [4:0]   g_exc [$];
    int           r_id [$];
    logic [31:0]  r_data [$];
    logic [4:0]   r_exc [$];
    int           onehot_viol = 0;
    int           ready_busy_viol = 0;
    int           respmulti_viol = 0;

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*TW +: TW] = op_a[i];
            req_b[i*TW +: TW] = op_b[i];
            req_rm[i*3 +: 3]  = op_rm[i];
        end
        req_valid = pend;
    endtask

    task automatic new_ops(input int i);
        op_a[i]  = $urandom;
        op_b[i]  = $urandom;
        op_rm[i] = 3'($urandom_range(0, 4));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        pend = '0;
        req_valid = '0;
        req_cancel = '0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mptr = 0;
    endtask

    // Acts as all requesters until `want` responses are taken or the budget runs out.
    task automatic run(input int want, input int budget, output int got);
        int cyc;
        cyc = 0;
        got = 0;
        g_id.delete(); g_exp.delete(); g_exc.delete();
        r_id.delete(); r_data.delete(); r_exc.delete();
        while (got < want && cyc < budget) begin
            @(negedge clk);
            drive_ops();
            resp_ready = rand_rr ? 4'($urandom_range(0, 15)) : 4'hF;
            #1;
            if ($countones(req_ready) > 1) onehot_viol++;
            if (req_ready != '0 && busy) ready_busy_viol++;
            if ($countones(resp_valid) > 1) respmulti_viol++;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    g_id.push_back(i);
                    g_exp.push_back(div_model(op_a[i], op_b[i], op_rm[i]));
                    g_exc.push_back(exc_model(op_a[i], op_b[i], op_rm[i]));
                    if (cont[i]) new_ops(i);
                    else pend[i] = 1'b0;
                end
                if (resp_valid[i] && resp_ready[i]) begin
                    r_id.push_back(i);
                    r_data.push_back(resp_data);
                    r_exc.push_back(resp_exc);
                    got++;
                end
            end
            cyc++;
        end
        req_valid = '0;
    endtask

    task automatic issue_until_wait(input int k, output bit ok);
        int cyc;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 100) begin
            @(negedge clk);
            drive_ops();
            resp_ready = '1;
            #1;
            if (req_ready[k] && req_valid[k]) pend[k] = 1'b0;
            if (div_in_valid && div_in_ready) ok = 1'b1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        checks++; if (resp_exc !== '0) begin errors++; $display("FAIL reset_resp_exc: got %b want 0", resp_exc); end
        checks++; if (div_in_valid !== 1'b0 || div_cancel !== 1'b0) begin errors++; $display("FAIL reset_div_ctrl: in_valid %b cancel %b want 0 0", div_in_valid, div_cancel); end
        checks++; if (div_a !== '0 || div_b !== '0 || div_rm !== '0) begin errors++; $display("FAIL reset_div_ops: %h %h %h want 0", div_a, div_b, div_rm); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        int got, i0;
        i0 = inval_cycles;
        op_a[0] = 32'h40C0_0000; op_b[0] = 32'h4000_0000; op_rm[0] = 3'd0;
        pend = 4'b0001;
        stub_lat = 3; stub_lat_rand = 1'b0; rand_rr = 1'b0;
        run(1, 100, got);
        checks++; if (got !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got); end
        if (got == 1) begin
            checks++; if (r_id[0] !== 0) begin errors++; $display("FAIL single_owner: got %0d want 0", r_id[0]); end
            checks++; if (r_data[0] !== 32'h4040_0000) begin errors++; $display("FAIL single_data: got %h want 40400000", r_data[0]); end
            checks++; if (r_exc[0] !== 5'd0) begin errors++; $display("FAIL single_exc: got %b want 00000", r_exc[0]); end
        end
        checks++; if (last_a !== 32'h40C0_0000 || last_b !== 32'h4000_0000) begin errors++; $display("FAIL single_operands: got %h %h want 40c00000 40000000", last_a, last_b); end
        @(negedge clk); #1;
        checks++; if (inval_cycles - i0 !== 1) begin errors++; $display("FAIL single_in_valid_cycles: got %0d want 1", inval_cycles - i0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
        mptr = 1;
    endtask

    task automatic test_all_four();
        int got;
        int exp_q[$];
        logic [N-1:0] m;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i] = 32'hC140_0000; op_b[i] = 32'h4080_0000; op_rm[i] = 3'd0; cont[i] = 1'b0;
        end
        m = 4'hF;
        while (m != '0) begin
            exp_q.push_back(rr_pick(mptr, m));
            m[exp_q[$]] = 1'b0;
            mptr = (exp_q[$] + 1) % N;
        end
        pend = 4'hF; stub_lat_rand = 1'b1;
        run(4, 300, got);
        checks++; if (got !== 4) begin errors++; $display("FAIL all4_count: got %0d want 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++; if (r_id[k] !== exp_q[k]) begin errors++; $display("FAIL all4_order[%0d]: got %0d want %0d", k, r_id[k], exp_q[k]); end
            checks++; if (r_data[k] !== 32'hC040_0000) begin errors++; $display("FAIL all4_data[%0d]: got %h want c0400000", k, r_data[k]); end
        end
        checks++; if (onehot_viol !== 0) begin errors++; $display("FAIL all4_onehot: got %0d violations want 0", onehot_viol); end
    endtask

    task automatic test_alternate();
        int got;
        int exp_q[$];
        new_ops(1);
        pend = 4'b0010;
        run(1, 100, got);
        checks++; if (got !== 1 || g_id.size() != 1 || g_id[0] !== rr_pick(mptr, 4'b0010)) begin errors++; $display("FAIL alt_setup: got %0d responses want 1 from requester 1", got); end
        mptr = 2;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(rr_pick(mptr, 4'b1010));
            mptr = (exp_q[$] + 1) % N;
        end
        new_ops(1); new_ops(3);
        cont[1] = 1'b1; cont[3] = 1'b1;
        pend = 4'b1010;
        onehot_viol = 0;
        run(4, 400, got);
        cont[1] = 1'b0; cont[3] = 1'b0; pend = '0;
        checks++; if (got !== 4) begin errors++; $display("FAIL alt_count: got %0d want 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++; if (r_id[k] !== exp_q[k]) begin errors++; $display("FAIL alt_order[%0d]: got %0d want %0d", k, r_id[k], exp_q[k]); end
            checks++; if (r_data[k] !== g_exp[k] || r_exc[k] !== g_exc[k]) begin errors++; $display("FAIL alt_data[%0d]: got %h/%b want %h/%b", k, r_data[k], r_exc[k], g_exp[k], g_exc[k]); end
        end
        checks++; if (onehot_viol !== 0) begin errors++; $display("FAIL alt_onehot: got %0d violations want 0", onehot_viol); end
    endtask

    task automatic test_random();
        int got;
        logic [N-1:0] m;
        rand_rr = 1'b1; stub_lat_rand = 1'b1;
        ready_busy_viol = 0; respmulti_viol = 0;
        for (int r = 0; r < 8; r++) begin
            int exp_q[$];
            m = 4'($urandom_range(1, 15));
            pend = m;
            for (int i = 0; i < N; i++) new_ops(i);
            while (m != '0) begin
                exp_q.push_back(rr_pick(mptr, m));
                m[exp_q[$]] = 1'b0;
                mptr = (exp_q[$] + 1) % N;
            end
            run(exp_q.size(), 800, got);
            checks++; if (got !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, got, exp_q.size()); end
            for (int k = 0; k < got; k++) begin
                checks++; if (r_id[k] !== exp_q[k] || r_data[k] !== g_exp[k] || r_exc[k] !== g_exc[k]) begin
                    errors++; $display("FAIL rand%0d_resp[%0d]: got id %0d %h/%b want id %0d %h/%b", r, k, r_id[k], r_data[k], r_exc[k], exp_q[k], g_exp[k], g_exc[k]);
                end
            end
        end
        rand_rr = 1'b0;
        checks++; if (ready_busy_viol !== 0 || respmulti_viol !== 0) begin errors++; $display("FAIL rand_protocol: ready_busy %0d resp_multi %0d want 0 0", ready_busy_viol, respmulti_viol); end
    endtask

    task automatic test_backpressure();
        int w, o, acc, cyc, got;
        bit seen;
        logic [31:0] d0;
        new_ops(0); new_ops(2);
        stub_lat_rand = 1'b0; stub_lat = 2;
        w = rr_pick(mptr, 4'b0101);
        o = (w == 0) ? 2 : 0;
        pend = 4'b0101;
        acc = -1; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            drive_ops();
            resp_ready = '0;
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) begin acc = i; pend[i] = 1'b0; end
            if (resp_valid != '0) seen = 1'b1;
            cyc++;
        end
        d0 = resp_data;
        checks++; if (!seen || acc !== w) begin errors++; $display("FAIL bp_first_grant: seen %0d got %0d want %0d", seen, acc, w); end
        checks++; if (d0 !== div_model(op_a[w], op_b[w], op_rm[w])) begin errors++; $display("FAIL bp_data: got %h want %h", d0, div_model(op_a[w], op_b[w], op_rm[w])); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive_ops();
            #1;
            checks++; if (resp_valid !== 4'(1 << w) || resp_data !== d0 || req_ready !== '0) begin
                errors++; $display("FAIL bp_hold[%0d]: resp_valid %b data %h req_ready %b want %b %h 0000", c, resp_valid, resp_data, req_ready, 4'(1 << w), d0);
            end
        end
        run(1, 50, got);
        checks++; if (got !== 1 || r_id[0] !== w || r_data[0] !== d0) begin errors++; $display("FAIL bp_release: got %0d responses want one from %0d", got, w); end
        mptr = (w + 1) % N;
        run(1, 100, got);
        checks++; if (got !== 1 || r_id[0] !== o || r_data[0] !== div_model(op_a[o], op_b[o], op_rm[o])) begin errors++; $display("FAIL bp_next: got %0d responses want one from %0d", got, o); end
        mptr = (o + 1) % N;
    endtask

    task automatic test_cancel();
        bit ok, anyresp;
        int cc0, ic0, cyc;
        // cancel while waiting on the divider
        new_ops(2); pend = 4'b0100; stub_lat = 15;
        cc0 = cancel_cycles;
        issue_until_wait(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cw_issue: timeout reaching WAIT, got 0 want 1"); end
        @(negedge clk); req_cancel = 4'b0100; #1;
        checks++; if (div_cancel !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cw_pulse: div_cancel %b busy %b want 1 1", div_cancel, busy); end
        @(negedge clk); req_cancel = '0; #1;
        checks++; if (div_cancel !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cw_after: div_cancel %b busy %b want 0 0", div_cancel, busy); end
        anyresp = 1'b0;
        repeat (20) begin @(negedge clk); #1; if (resp_valid != '0) anyresp = 1'b1; end
        checks++; if (anyresp !== 1'b0) begin errors++; $display("FAIL cw_no_resp: got resp_valid want none"); end
        checks++; if (cancel_cycles - cc0 !== 1) begin errors++; $display("FAIL cw_pulse_len: got %0d cycles want 1", cancel_cycles - cc0); end
        mptr = 3;

        // cancel before the divider accepts
        new_ops(1); pend = 4'b0010; in_ready_en = 1'b0;
        ic0 = issue_cnt; cyc = 0; ok = 1'b0;
        while (!ok && cyc < 50) begin
            @(negedge clk); drive_ops(); #1;
            if (req_ready[1] && req_valid[1]) begin ok = 1'b1; pend[1] = 1'b0; end
            cyc++;
        end
        @(negedge clk); drive_ops(); #1;
        checks++; if (!ok || div_in_valid !== 1'b1) begin errors++; $display("FAIL ci_issue: accepted %0d div_in_valid %b want 1 1", ok, div_in_valid); end
        req_cancel = 4'b0010; #1;
        checks++; if (div_in_valid !== 1'b0) begin errors++; $display("FAIL ci_withdraw: div_in_valid %b want 0", div_in_valid); end
        @(negedge clk); req_cancel = '0; in_ready_en = 1'b1; #1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || issue_cnt !== ic0) begin errors++; $display("FAIL ci_dropped: busy %b issues %0d want 0 %0d", busy, issue_cnt, ic0); end
        mptr = 2;

        // cancel coincident with the divider result
        new_ops(0); pend = 4'b0001; stub_lat = 3;
        cc0 = cancel_cycles;
        issue_until_wait(0, ok);
        cyc = 0;
        while (div_out_valid !== 1'b1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        checks++; if (!ok || div_out_valid !== 1'b1) begin errors++; $display("FAIL cc_wait: out_valid %b want 1", div_out_valid); end
        req_cancel = 4'b0001; #1;
        checks++; if (div_cancel !== 1'b1) begin errors++; $display("FAIL cc_pulse: div_cancel %b want 1", div_cancel); end
        @(negedge clk); req_cancel = '0;
        anyresp = 1'b0;
        repeat (15) begin @(negedge clk); #1; if (resp_valid != '0) anyresp = 1'b1; end
        checks++; if (anyresp !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cc_dropped: resp seen %0d busy %b want 0 0", anyresp, busy); end
        mptr = 1;
    endtask

    task automatic test_reset_mid_wait();
        bit ok, anyresp;
        int oc0, got;
        int exp_q[$];
        new_ops(2); pend = 4'b0100; stub_lat = 8;
        oc0 = outv_cnt;
        issue_until_wait(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rw_issue: timeout reaching WAIT, got 0 want 1"); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (resp_valid !== '0 || resp_data !== '0 || resp_exc !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL rw_outputs: resp_valid %b data %h exc %b req_ready %b want all 0", resp_valid, resp_data, resp_exc, req_ready);
        end
        checks++; if (busy !== 1'b0 || div_in_valid !== 1'b0 || div_cancel !== 1'b0 || div_a !== '0 || div_b !== '0 || div_rm !== '0) begin
            errors++; $display("FAIL rw_div_side: busy %b in_valid %b cancel %b a %h b %h rm %h want all 0", busy, div_in_valid, div_cancel, div_a, div_b, div_rm);
        end
        anyresp = 1'b0;
        repeat (15) begin @(negedge clk); #1; if (resp_valid != '0) anyresp = 1'b1; end
        checks++; if (anyresp !== 1'b0 || outv_cnt == oc0) begin errors++; $display("FAIL rw_late_result: resp seen %0d late results %0d want 0 and >0", anyresp, outv_cnt - oc0); end
        mptr = 0;
        op_a[0] = 32'h40C0_0000; op_b[0] = 32'h4000_0000; op_rm[0] = 3'd0;
        new_ops(3);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(rr_pick(mptr, (k == 0) ? 4'b1001 : 4'b1000));
            mptr = (exp_q[$] + 1) % N;
        end
        pend = 4'b1001;
        run(2, 200, got);
        checks++; if (got !== 2) begin errors++; $display("FAIL rw_recover_count: got %0d want 2", got); end
        for (int k = 0; k < got; k++) begin
            checks++; if (r_id[k] !== exp_q[k] || r_data[k] !== g_exp[k]) begin errors++; $display("FAIL rw_recover[%0d]: got id %0d %h want id %0d %h", k, r_id[k], r_data[k], exp_q[k], g_exp[k]); end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_rm[i] = '0; cont[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_random();
        test_backpressure();
        test_cancel();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin arbiter and sequencer that shares one floating-point `divider` instance between `NUM_REQ` requesters. It accepts one request at a time, issues it through the divider's `in_valid`/`in_ready` handshake, and waits for `out_valid`. It then returns the quotient and exception flags to the owning requester through a valid/ready response port. It sits between the neuron datapath lanes and the divider, and keeps exactly one operation outstanding because the divider is iterative and unbuffered.

## Interface
- `exp_width`, 8, exponent width passed to the divider.
- `mant_width`, 24, mantissa width passed to the divider; `total_width = exp_width + mant_width`.
- `NUM_REQ`, 4, number of requesters (2..8); `ID_W = $clog2(NUM_REQ)`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_a`, `req_b`  in  NUM_REQ*total_width  flattened dividend/divisor; requester i occupies slice [i*total_width +: total_width].
- `req_round_mode`  in  NUM_REQ*3  flattened rounding mode.
- `req_cancel`  in  NUM_REQ  abort the in-flight operation if owned by requester i.
- `resp_valid`  out  NUM_REQ  result available for requester i.
- `resp_ready`  in  NUM_REQ  requester i takes the result.
- `resp_data`  out  total_width  quotient, shared bus, valid for the owner only.
- `resp_exc`  out  5  exception flags, shared bus.
- `busy`  out  1  high whenever the state is not IDLE.
- `div_in_valid`, `div_a`, `div_b`, `div_round_mode`, `div_cancel`  out  1/total_width/total_width/3/1  divider inputs.
- `div_in_ready`, `div_out_valid`, `div_out`, `div_exceptions`  in  1/1/total_width/5  divider outputs.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Registers: `owner` [ID_W], `rr_ptr` [ID_W], operand/round-mode latches, result/exception latches.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit scanning from `rr_ptr` upward, with modulo `NUM_REQ` wrap.
  - Assert `req_ready[winner]` combinationally in the same cycle.
  - Latch that requester's a, b and round_mode, set `owner = winner`, and go to ISSUE.
- ISSUE:
  - Drive `div_in_valid=1` with the latched operands.
  - When `div_in_ready` is high, go to WAIT; otherwise hold.
  - If `req_cancel[owner]` is high, drop the request and go to IDLE without issuing.
- WAIT:
  - `div_in_valid=0`.
  - On `div_out_valid`, latch `div_out` and `div_exceptions` and go to RESP.
  - If `req_cancel[owner]` is high, pulse `div_cancel` for exactly one cycle and go to IDLE; no response is produced.
  - If cancel and `div_out_valid` occur in the same cycle, cancel wins and the result is discarded.
- RESP:
  - `resp_valid[owner]=1`, with `resp_data`/`resp_exc` from the latches, held stable.
  - On `resp_ready[owner]`, go to IDLE and set `rr_ptr = (owner+1) mod NUM_REQ`.
  - `req_cancel` is ignored in this state.
- `rr_ptr` also advances past the owner after a cancel.
- `resp_valid` bits other than the owner's are always 0.
- `resp_data` holds its last value when `resp_valid` is low.
- No arithmetic is done here; operands pass through bit-exact.

## Timing
- Reset values:
  - `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_exc=0`.
  - `div_in_valid=0`, `div_cancel=0`, `div_a=0`, `div_b=0`, `div_round_mode=0`.
  - `busy=0`, `rr_ptr=0`, `owner=0`, state IDLE.
- Latency with no stalls:
  - Request accepted at cycle T (IDLE, `req_ready` high).
  - `div_in_valid` high at T+1; with `div_in_ready` high, WAIT starts at T+2.
  - `resp_valid` rises the cycle after `div_out_valid`.
  - Return to IDLE the cycle after `resp_ready`, so a new request can be accepted at that cycle.
- Minimum spacing between two accepts is therefore divider latency + 4 cycles.
- `req_ready` is never high outside IDLE.
- `div_in_valid` is high only in ISSUE.
- `rst` during any state forces the reset values on the next edge. A divider result arriving after reset is ignored, because the FSM is in IDLE and IDLE does not watch `div_out_valid`.
- `div_out_valid` outside WAIT is ignored.
- `req_valid` may drop before acceptance; no request is latched unless `req_ready` and `req_valid` are both high.

## Test plan
- Single request from requester 0, a=0x40C00000 (6.0), b=0x40000000 (2.0), round_mode=0:
  - the divider sees exactly one `in_valid` cycle;
  - `resp_valid[0]` is high with `resp_data`=0x40400000 and `resp_exc`=00000;
  - `busy` returns to 0.
- All four requesters assert together after reset. Each has a=0xC1400000 (-12.0) and b=0x40800000 (4.0). Grants must come in order 0,1,2,3, and every response must be 0xC0400000.
- Requesters 1 and 3 request continuously with `rr_ptr` starting at 2. Grants must go 3,1,3,1 with no starvation. `req_ready` must be one-hot or zero every cycle.
- Response backpressure: hold `resp_ready[owner]=0` for 10 cycles. `resp_valid` and `resp_data` stay stable, and no new request is accepted until the handshake completes.
- Cancel scenarios:
  - Assert `req_cancel[owner]` in WAIT. Expect a one-cycle `div_cancel` pulse, no `resp_valid`, and return to IDLE.
  - Repeat with cancel coincident with `div_out_valid`. The result is still dropped.
- Assert `rst` for one cycle mid-WAIT. All outputs return to their reset values. A late `div_out_valid` produces no response, and the next request from requester 0 completes normally.
